// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared width, types and binary->Gray helper for the Gray counter
//
// Purpose : common definitions for gray_counter_32 and gray_encoder.
// Contents: GW     - default code width (multiple of 8, decoder works in bytes)
//           gray_t - GW-bit Gray-coded word
//           bin_t  - GW-bit binary word
//           bin2gray(b) - reflected Gray image of b
package gray_pkg;

  localparam int GW = 32;

  typedef logic [GW-1:0] gray_t;
  typedef logic [GW-1:0] bin_t;

  function automatic gray_t bin2gray(bin_t b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_encoder.sv
// rtl/gray_encoder.sv - combinational W-bit binary to reflected Gray encoder
//
// Purpose : produces the Gray image of a binary word; used to form the
//           next-state value of the counter's registered Gray output.
// Ports   : bin  in  W  binary value
//           gray out W  bin ^ (bin >> 1)
module gray_encoder
  import gray_pkg::*;
#(
  parameter int W = GW
) (
  input  logic [W-1:0] bin,
  output logic [W-1:0] gray
);

  // The package helper is fixed at GW bits; other widths use the same
  // expression directly.
  if (W == GW) begin : g_pkg_width
    assign gray = bin2gray(bin);
  end else begin : g_any_width
    assign gray = bin ^ (bin >> 1);
  end

endmodule

// File: rtl/gray_counter_32.sv
// rtl/gray_counter_32.sv - registered up/down counter with Gray-coded output and valid/ready handshake
//
// Purpose : counts up or down in a binary shadow register and offers the
//           count as reflected Gray code (single-bit change per step, wrap
//           included) to the downstream Gray decoder.
// Ports   : clk      in  1  clock, rising edge
//           rst      in  1  asynchronous, active-high reset
//           en       in  1  request one count step
//           up       in  1  direction: 1 = +1, 0 = -1
//           load     in  1  load ld_val; priority over en
//           ld_val   in  W  binary value for load
//           g        out W  current count, Gray code (registered)
//           o_valid  out 1  g holds a word not yet consumed
//           o_ready  in  1  consumer accepts g this cycle
//           wrap     out 1  one-cycle pulse after a max->0 or 0->max step
// Config  : GRAY_CNT_SATURATE_EN - when defined, a step that would wrap holds
//           the count instead; o_valid is still set and wrap still pulses.
module gray_counter_32
  import gray_pkg::*;
#(
  parameter int           W       = GW,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] g,
  output logic         o_valid,
  input  logic         o_ready,
  output logic         wrap
);

  logic [W-1:0] b;
  logic [W-1:0] b_step;
  logic [W-1:0] b_nxt;
  logic [W-1:0] g_nxt;
  logic         accept;
  logic         step;
  logic         at_edge;

  assign accept = o_valid & o_ready;

  // A full, unaccepted output blocks the step; the request is simply dropped.
  assign step = en & ~load & (~o_valid | o_ready);

  // The step about to be taken would cross max->0 (up) or 0->max (down).
  assign at_edge = up ? (&b) : ~(|b);

`ifdef GRAY_CNT_SATURATE_EN
  assign b_step = at_edge ? b : (up ? b + W'(1) : b - W'(1));
`else
  assign b_step = up ? b + W'(1) : b - W'(1);
`endif

  assign b_nxt = load ? ld_val : b_step;

  // g is registered from the encoded next binary value, so the output never
  // has a combinational path from the inputs and always matches b.
  gray_encoder #(
    .W(W)
  ) u_enc (
    .bin  (b_nxt),
    .gray (g_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b       <= RST_VAL;
      g       <= RST_VAL ^ (RST_VAL >> 1);
      o_valid <= 1'b0;
      wrap    <= 1'b0;
    end else if (load) begin
      // Overwrites any pending word, even one the consumer has not taken.
      b       <= b_nxt;
      g       <= g_nxt;
      o_valid <= 1'b1;
      wrap    <= 1'b0;
    end else if (step) begin
      b       <= b_nxt;
      g       <= g_nxt;
      o_valid <= 1'b1;
      wrap    <= at_edge;
    end else begin
      o_valid <= o_valid & ~accept;
      wrap    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gray_counter_32.sv
// tb/tb_gray_counter_32.sv - self-checking bench for gray_counter_32
module tb_gray_counter_32;

  localparam int W = 32;

`ifdef GRAY_CNT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] ld_val;
  logic [W-1:0] g;
  logic         o_valid;
  logic         o_ready;
  logic         wrap;

  gray_counter_32 dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .up      (up),
    .load    (load),
    .ld_val  (ld_val),
    .g       (g),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] g;
    logic [W-1:0] b;
    logic [W-1:0] prev_g;
    logic         valid;
    logic         wrap;
    logic         stepped;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mb;
  logic         mv;
  logic         mw;

  function automatic logic [W-1:0] to_gray(logic [W-1:0] v);
    return v ^ (v >> 1);
  endfunction

  function automatic logic [W-1:0] from_gray(logic [W-1:0] v);
    logic [W-1:0] r;
    r[W-1] = v[W-1];
    for (int i = W - 2; i >= 0; i--) r[i] = r[i+1] ^ v[i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mb = '0;
    mv = 1'b0;
    mw = 1'b0;
    sb.delete();
  endtask

  // Drive one cycle of inputs, push the model's prediction, then compare after the edge.
  task automatic cyc(input logic e, input logic u, input logic l,
                     input logic [W-1:0] lv, input logic r);
    exp_t         x;
    logic         stp;
    logic         edge_hit;
    en = e; up = u; load = l; ld_val = lv; o_ready = r;
    x.prev_g = to_gray(mb);
    stp = e & ~l & (~mv | r);
    if (l) begin
      mb = lv; mv = 1'b1; mw = 1'b0;
    end else if (stp) begin
      edge_hit = u ? (mb == '1) : (mb == '0);
      if (!(edge_hit && SAT)) mb = u ? mb + 1 : mb - 1;
      mv = 1'b1; mw = edge_hit;
    end else begin
      mv = mv & ~r; mw = 1'b0;
    end
    x.g = to_gray(mb);
    x.b = mb;
    x.valid = mv;
    x.wrap = mw;
    x.stepped = stp && (x.g != x.prev_g);
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check("g", g, x.g);
    check("o_valid", W'(o_valid), W'(x.valid));
    check("wrap", W'(wrap), W'(x.wrap));
    check("decode", from_gray(g), x.b);
    if (x.stepped) check("one_bit", W'($countones(g ^ x.prev_g)), W'(1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    check("rst_g", g, '0);
    check("rst_valid", W'(o_valid), '0);
    check("rst_wrap", W'(wrap), '0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [W-1:0] t2_exp [5];
  logic [W-1:0] lv;

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; ld_val = '0; o_ready = 1'b0;
    t2_exp[0] = 32'd1; t2_exp[1] = 32'd3; t2_exp[2] = 32'd2;
    t2_exp[3] = 32'd6; t2_exp[4] = 32'd7;
    #2;
    do_reset();

    // T2: five up steps with the consumer always ready
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b1, 1'b0, '0, 1'b1);
      check("t2_g", g, t2_exp[i]);
      check("t2_dec", from_gray(g), W'(i + 1));
    end

    // T1: asynchronous reset in the middle of a run
    do_reset();

    // T3: load all-ones, then step up across the top
    cyc(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
    check("t3_load_g", g, 32'h8000_0000);
    cyc(1'b1, 1'b1, 1'b0, '0, 1'b1);
    check("t3_wrap", W'(wrap), W'(1));
    check("t3_g", g, SAT ? 32'h8000_0000 : 32'h0);
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b1);
    check("t3_wrap_clr", W'(wrap), '0);

    // T4: step down from zero
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
    check("t4_g", g, SAT ? 32'h0 : 32'h8000_0000);
    check("t4_wrap", W'(wrap), W'(1));

    // T5: stalled consumer freezes the word
    do_reset();
    cyc(1'b1, 1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, 1'b0, '0, 1'b0);
      check("t5_frozen_g", g, 32'd1);
      check("t5_valid", W'(o_valid), W'(1));
    end
    cyc(1'b1, 1'b1, 1'b0, '0, 1'b1);
    check("t5_release_g", g, 32'd3);

    // Load while stalled overwrites the pending word
    cyc(1'b1, 1'b1, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 32'd10, 1'b0);
    check("ld_stall_g", g, to_gray(32'd10));

    // T6: random traffic against the model
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      case ($urandom_range(0, 3))
        0: lv = '0;
        1: lv = '1;
        2: lv = 32'h7FFF_FFFF + $urandom_range(0, 2);
        default: lv = $urandom;
      endcase
      cyc(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
          ($urandom_range(0, 15) == 0), lv, ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
